branch_target_unit: RTL and testbench

BRANCH_TARGET_UNIT -- requirements
Module: branch_target_unit

---
 rtl/branch_target_unit_if.sv | 29 ++
 rtl/branch_target_unit.sv | 99 +++++++++
 tb/tb_branch_target_unit.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/branch_target_unit_if.sv
// Control/status bundle for branch_target_unit: execution control, branch
// request, target-table write port and PC/done status.
interface branch_target_unit_if #(
    parameter int unsigned PC_W  = 10,
    parameter int unsigned IDX_W = 3
);
    logic             start;
    logic             halt_in;
    logic             branch_en;
    logic [IDX_W-1:0] how_high;
    logic             lut_we;
    logic [IDX_W-1:0] lut_waddr;
    logic [PC_W-1:0]  lut_wdata;
    logic             lut_wabs;
    logic [PC_W-1:0]  pc_out;
    logic             done;

    modport master (
        output start, halt_in, branch_en, how_high,
        output lut_we, lut_waddr, lut_wdata, lut_wabs,
        input  pc_out, done
    );

    modport slave (
        input  start, halt_in, branch_en, how_high,
        input  lut_we, lut_waddr, lut_wdata, lut_wabs,
        output pc_out, done
    );
endinterface

// File: rtl/branch_target_unit.sv
// PC sequencer with an IDLE/RUN/HALT FSM and a target table holding relative or
// absolute branch targets. Define BTU_WRITE_FWD_EN to forward same-cycle table writes.
module branch_target_unit #(
    parameter int unsigned PC_W  = 10,
    parameter int unsigned IDX_W = 3
) (
    input logic                  Clk,
    input logic                  Reset_n,
    branch_target_unit_if.slave  bus
);
    localparam int unsigned DEPTH = 1 << IDX_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;

    logic [PC_W-1:0] lut_val_q [DEPTH];
    logic            lut_abs_q [DEPTH];

    logic [PC_W-1:0] entry_val;
    logic            entry_abs;

    // Entry k resets to +/- 2^(k/2+1); shifts past PC_W truncate to zero.
    function automatic logic [PC_W-1:0] reset_entry(input int unsigned k);
        logic [PC_W-1:0] mag;
        mag = PC_W'(1) << (k / 2 + 1);
        return ((k % 2) == 1) ? -mag : mag;
    endfunction

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                lut_val_q[IDX_W'(k)] <= reset_entry(k);
                lut_abs_q[IDX_W'(k)] <= 1'b0;
            end
        end else if (bus.lut_we) begin
            lut_val_q[bus.lut_waddr] <= bus.lut_wdata;
            lut_abs_q[bus.lut_waddr] <= bus.lut_wabs;
        end
    end

    always_comb begin
        entry_val = lut_val_q[bus.how_high];
        entry_abs = lut_abs_q[bus.how_high];
`ifdef BTU_WRITE_FWD_EN
        if (bus.lut_we && (bus.lut_waddr == bus.how_high)) begin
            entry_val = bus.lut_wdata;
            entry_abs = bus.lut_wabs;
        end
`else
`endif
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        unique case (state_q)
            IDLE, HALT: begin
                if (bus.start) begin
                    state_d = RUN;
                    pc_d    = '0;
                end
            end
            RUN: begin
                // Halt wins over a simultaneous branch request.
                if (bus.halt_in) begin
                    state_d = HALT;
                end else if (bus.branch_en) begin
                    pc_d = entry_abs ? entry_val : pc_q + entry_val;
                end else begin
                    pc_d = pc_q + PC_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                pc_d    = '0;
            end
        endcase
    end

    assign bus.pc_out = pc_q;
    assign bus.done   = (state_q == HALT);

endmodule

// File: tb/tb_branch_target_unit.sv
// Directed self-checking bench for branch_target_unit at PC_W=10, IDX_W=3.
module tb_branch_target_unit;
    localparam int unsigned PC_W  = 10;
    localparam int unsigned IDX_W = 3;

    logic clk;
    logic rst_n;

    int unsigned n_checks;
    int unsigned n_pass;

    branch_target_unit_if #(.PC_W(PC_W), .IDX_W(IDX_W)) bus ();

    branch_target_unit #(.PC_W(PC_W), .IDX_W(IDX_W)) dut (
        .Clk     (clk),
        .Reset_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) tick();
    endtask

    task automatic idle_inputs();
        bus.start     = 1'b0;
        bus.halt_in   = 1'b0;
        bus.branch_en = 1'b0;
        bus.how_high  = '0;
        bus.lut_we    = 1'b0;
        bus.lut_waddr = '0;
        bus.lut_wdata = '0;
        bus.lut_wabs  = 1'b0;
    endtask

    task automatic restart();
        bus.halt_in = 1'b1;
        tick();
        bus.halt_in = 1'b0;
        bus.start   = 1'b1;
        tick();
        bus.start   = 1'b0;
    endtask

    logic [31:0] exp_fwd;
    logic [31:0] wrap_exp [4];

    initial begin
        n_checks = 0;
        n_pass   = 0;
        idle_inputs();
        rst_n = 1'b0;
        #1;
        check("reset_pc", 32'(bus.pc_out), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        #15 rst_n = 1'b1;

        // Sequential count after start
        bus.start = 1'b1;
        tick();
        check("start_pc0", 32'(bus.pc_out), 32'd0);
        bus.start = 1'b0;
        tick();
        check("seq_pc1", 32'(bus.pc_out), 32'd1);
        tick();
        check("seq_pc2", 32'(bus.pc_out), 32'd2);
        tick();
        check("seq_pc3", 32'(bus.pc_out), 32'd3);
        check("seq_done", 32'(bus.done), 32'd0);
        run(2);
        check("seq_pc5", 32'(bus.pc_out), 32'd5);

        // Relative branches
        bus.branch_en = 1'b1;
        bus.how_high  = 3'd1;
        tick();
        check("br_idx1", 32'(bus.pc_out), 32'd3);
        bus.how_high  = 3'd6;
        tick();
        check("br_idx6", 32'(bus.pc_out), 32'd19);
        bus.branch_en = 1'b0;

        // Halt then restart, negative wrap
        bus.halt_in = 1'b1;
        tick();
        check("halt_pc", 32'(bus.pc_out), 32'd19);
        check("halt_done", 32'(bus.done), 32'd1);
        bus.halt_in = 1'b0;
        bus.start   = 1'b1;
        tick();
        check("restart_pc", 32'(bus.pc_out), 32'd0);
        check("restart_done", 32'(bus.done), 32'd0);
        bus.start = 1'b0;
        tick();
        check("pc1", 32'(bus.pc_out), 32'd1);
        bus.branch_en = 1'b1;
        bus.how_high  = 3'd7;
        tick();
        check("br_wrap_neg", 32'(bus.pc_out), 32'd1009);
        bus.branch_en = 1'b0;

        // Absolute entry to reach 1020, then increment wrap
        bus.lut_we    = 1'b1;
        bus.lut_waddr = 3'd0;
        bus.lut_wdata = 10'd1020;
        bus.lut_wabs  = 1'b1;
        tick();
        check("inc_1010", 32'(bus.pc_out), 32'd1010);
        bus.lut_we    = 1'b0;
        bus.branch_en = 1'b1;
        bus.how_high  = 3'd0;
        tick();
        check("br_abs_1020", 32'(bus.pc_out), 32'd1020);
        bus.branch_en = 1'b0;
        wrap_exp = '{32'd1021, 32'd1022, 32'd1023, 32'd0};
        for (int i = 0; i < 4; i++) begin
            tick();
            check("inc_wrap", 32'(bus.pc_out), wrap_exp[i]);
        end

        // Same-cycle write and branch on idx2 at PC=7
        run(7);
        check("pc7_a", 32'(bus.pc_out), 32'd7);
        bus.branch_en = 1'b1;
        bus.how_high  = 3'd2;
        bus.lut_we    = 1'b1;
        bus.lut_waddr = 3'd2;
        bus.lut_wdata = 10'd100;
        bus.lut_wabs  = 1'b1;
        tick();
`ifdef BTU_WRITE_FWD_EN
        exp_fwd = 32'd100;
`else
        exp_fwd = 32'd11;
`endif
        check("wr_br_same", 32'(bus.pc_out), exp_fwd);
        idle_inputs();

        // Branch using the now-written absolute entry
        restart();
        run(7);
        check("pc7_b", 32'(bus.pc_out), 32'd7);
        bus.branch_en = 1'b1;
        bus.how_high  = 3'd2;
        tick();
        check("br_abs_100", 32'(bus.pc_out), 32'd100);
        bus.branch_en = 1'b0;

        // Halt has priority over branch; HALT ignores both
        restart();
        run(9);
        check("pc9", 32'(bus.pc_out), 32'd9);
        bus.halt_in   = 1'b1;
        bus.branch_en = 1'b1;
        bus.how_high  = 3'd1;
        tick();
        check("halt_prio_pc", 32'(bus.pc_out), 32'd9);
        check("halt_prio_done", 32'(bus.done), 32'd1);
        tick();
        check("halt_hold_pc", 32'(bus.pc_out), 32'd9);
        bus.halt_in   = 1'b0;
        bus.branch_en = 1'b0;
        bus.start     = 1'b1;
        tick();
        check("halt_start_pc", 32'(bus.pc_out), 32'd0);
        check("halt_start_done", 32'(bus.done), 32'd0);
        bus.start = 1'b0;

        // Asynchronous reset pulse mid-RUN
        run(40);
        check("pc40", 32'(bus.pc_out), 32'd40);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_pc", 32'(bus.pc_out), 32'd0);
        check("async_rst_done", 32'(bus.done), 32'd0);
        #1 rst_n = 1'b1;
        tick();
        check("idle_after_rst", 32'(bus.pc_out), 32'd0);
        bus.branch_en = 1'b1;
        bus.how_high  = 3'd1;
        tick();
        check("idle_ignore_br", 32'(bus.pc_out), 32'd0);
        bus.branch_en = 1'b0;
        bus.start     = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        check("post_rst_pc1", 32'(bus.pc_out), 32'd1);
        bus.branch_en = 1'b1;
        bus.how_high  = 3'd2;
        tick();
        check("tbl_restored_idx2", 32'(bus.pc_out), 32'd5);
        bus.how_high  = 3'd0;
        tick();
        check("tbl_restored_idx0", 32'(bus.pc_out), 32'd7);
        idle_inputs();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
